// File: rtl/elevator_scheduler.sv
// -----------------------------------------------------------------------------
// elevator_scheduler
//
// SCAN request scheduler for one elevator car. It latches floor calls, keeps
// travelling in the current direction while calls remain ahead, and reverses
// only when nothing is left ahead. It emits one-cycle sus/jos step pulses to an
// external floor counter, reads that counter's etaj_curent back as position,
// and sequences the door open/dwell/close phase.
//
// Parameters
//   NUM_FLOORS   : served floors (2..8), floors 0..NUM_FLOORS-1
//   TRAVEL_TICKS : tick pulses of travel between adjacent floors (>=1)
//   DOOR_TICKS   : tick pulses of unobstructed door dwell (>=1)
//
// Ports
//   clk           in   clock, rising edge
//   reset         in   asynchronous active-low reset
//   tick          in   timebase enable for the travel/door counters
//   cerere[7:0]   in   call pulses, one per floor (bits >= NUM_FLOORS ignored)
//   etaj_curent   in   current floor from the floor counter
//   usa_blocata   in   door obstruction, level-sensitive
//   sus / jos     out  step-up / step-down pulse (only during STEP)
//   usa_deschisa  out  door-open command
//   cereri_active out  latched pending calls
//   directie      out  current/last travel direction (1 = up)
//   stare         out  state encoding for debug/display
// -----------------------------------------------------------------------------
module elevator_scheduler #(
  parameter int NUM_FLOORS   = 8,
  parameter int TRAVEL_TICKS = 50,
  parameter int DOOR_TICKS   = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic [7:0] cerere,
  input  logic [2:0] etaj_curent,
  input  logic       usa_blocata,
  output logic       sus,
  output logic       jos,
  output logic       usa_deschisa,
  output logic [7:0] cereri_active,
  output logic       directie,
  output logic [2:0] stare
);

  localparam int TW = $clog2(TRAVEL_TICKS + 1);
  localparam int DW = $clog2(DOOR_TICKS + 1);
  localparam logic [TW-1:0] TRAVEL_LAST = TW'(TRAVEL_TICKS - 1);
  localparam logic [DW-1:0] DOOR_LAST   = DW'(DOOR_TICKS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_MOVE   = 3'd1,
    S_STEP   = 3'd2,
    S_SETTLE = 3'd3,
    S_DOOR   = 3'd4
  } state_t;

  state_t        state_reg, state_next;
  logic          directie_reg, directie_next;
  logic [7:0]    cereri_reg, cereri_next;
  logic [TW-1:0] travel_cnt_reg, travel_cnt_next;
  logic [DW-1:0] door_cnt_reg, door_cnt_next;

  // Per-floor masks relative to the current position.
  logic [7:0] valid_mask, above_mask, below_mask, here_mask;

  for (genvar gi = 0; gi < 8; gi++) begin : g_mask
    assign valid_mask[gi] = (gi < NUM_FLOORS);
    assign above_mask[gi] = (etaj_curent < 3'(gi));
    assign below_mask[gi] = (etaj_curent > 3'(gi));
    assign here_mask[gi]  = (etaj_curent == 3'(gi));
  end

  // A position outside the served range is a fault: park and never step.
  logic floor_ok;
  assign floor_ok = (int'(etaj_curent) < NUM_FLOORS);

  logic calls_above, calls_below, here_pending, ahead, behind, cerere_here;
  assign calls_above  = |(cereri_reg & above_mask);
  assign calls_below  = |(cereri_reg & below_mask);
  assign here_pending = |(cereri_reg & here_mask);
  assign ahead        = directie_reg ? calls_above : calls_below;
  assign behind       = directie_reg ? calls_below : calls_above;
  assign cerere_here  = |(cerere & here_mask & valid_mask);

  logic       enter_door;
  logic [7:0] set_bits, clr_bits;

  always_comb begin
    state_next      = state_reg;
    directie_next   = directie_reg;
    travel_cnt_next = travel_cnt_reg;
    door_cnt_next   = door_cnt_reg;

    case (state_reg)
      // SETTLE shares the IDLE decision; with nothing to do both land in IDLE.
      S_IDLE, S_SETTLE: begin
        travel_cnt_next = '0;
        door_cnt_next   = '0;
        if (!floor_ok) begin
          state_next = S_IDLE;
        end else if (here_pending) begin
          state_next = S_DOOR;
        end else if (ahead) begin
          state_next = S_MOVE;
        end else if (behind) begin
          directie_next = ~directie_reg;
          state_next    = S_MOVE;
        end else begin
          state_next = S_IDLE;
        end
      end

      S_MOVE: begin
        if (!floor_ok) begin
          state_next = S_IDLE;
        end else if (tick) begin
          if (travel_cnt_reg == TRAVEL_LAST) begin
            state_next = S_STEP;
          end else begin
            travel_cnt_next = travel_cnt_reg + 1'b1;
          end
        end
      end

      S_STEP: begin
        state_next = floor_ok ? S_SETTLE : S_IDLE;
      end

      S_DOOR: begin
        if (!floor_ok) begin
          state_next = S_IDLE;
        end else if (usa_blocata || cerere_here) begin
          // Obstruction or a re-press of this floor restarts the dwell.
          door_cnt_next = '0;
        end else if (tick) begin
          if (door_cnt_reg == DOOR_LAST) begin
            state_next = S_IDLE;
          end else begin
            door_cnt_next = door_cnt_reg + 1'b1;
          end
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase

    enter_door = (state_next == S_DOOR) && (state_reg != S_DOOR);

    // While the door is open a call for this floor is absorbed by the door
    // timer instead of being latched.
    set_bits = cerere & valid_mask & ((state_reg == S_DOOR) ? ~here_mask : 8'hFF);
    // Clear applies after set, so it wins only for the floor being served.
    clr_bits    = enter_door ? here_mask : 8'h00;
    cereri_next = (cereri_reg | set_bits) & ~clr_bits;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= S_IDLE;
      directie_reg   <= 1'b1;
      cereri_reg     <= 8'h00;
      travel_cnt_reg <= '0;
      door_cnt_reg   <= '0;
    end else begin
      state_reg      <= state_next;
      directie_reg   <= directie_next;
      cereri_reg     <= cereri_next;
      travel_cnt_reg <= travel_cnt_next;
      door_cnt_reg   <= door_cnt_next;
    end
  end

  // Moore decode from registered state; directie is stable during STEP.
  assign sus           = (state_reg == S_STEP) &&  directie_reg && floor_ok;
  assign jos           = (state_reg == S_STEP) && !directie_reg && floor_ok;
  assign usa_deschisa  = (state_reg == S_DOOR);
  assign cereri_active = cereri_reg;
  assign directie      = directie_reg;
  assign stare         = state_reg;

endmodule

// File: tb/tb_elevator_scheduler.sv
module tb_elevator_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tick = 1'b1;
  logic [7:0] cerere = 8'h00;
  logic [2:0] etaj = 3'd0;
  logic       usa_blocata = 1'b0;
  logic       sus, jos, usa_deschisa, directie;
  logic [7:0] cereri_active;
  logic [2:0] stare;

  // Second instance with six floors for the out-of-range check.
  logic [7:0] cerere6 = 8'h00;
  logic [2:0] etaj6 = 3'd0;
  logic       sus6, jos6, usa6, directie6;
  logic [7:0] cereri6;
  logic [2:0] stare6;

  int checks = 0;
  int failures = 0;

  elevator_scheduler #(.NUM_FLOORS(8), .TRAVEL_TICKS(4), .DOOR_TICKS(3)) u_dut (
    .clk(clk), .reset(reset), .tick(tick), .cerere(cerere), .etaj_curent(etaj),
    .usa_blocata(usa_blocata), .sus(sus), .jos(jos), .usa_deschisa(usa_deschisa),
    .cereri_active(cereri_active), .directie(directie), .stare(stare));

  elevator_scheduler #(.NUM_FLOORS(6), .TRAVEL_TICKS(4), .DOOR_TICKS(3)) u_dut6 (
    .clk(clk), .reset(reset), .tick(tick), .cerere(cerere6), .etaj_curent(etaj6),
    .usa_blocata(1'b0), .sus(sus6), .jos(jos6), .usa_deschisa(usa6),
    .cereri_active(cereri6), .directie(directie6), .stare(stare6));

  always #5 clk = ~clk;

  // Floor counters, reset in parallel with the scheduler.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      etaj  <= 3'd0;
      etaj6 <= 3'd0;
    end else begin
      if (sus && etaj != 3'd7) etaj <= etaj + 3'd1;
      else if (jos && etaj != 3'd0) etaj <= etaj - 3'd1;
      if (sus6 && etaj6 != 3'd7) etaj6 <= etaj6 + 3'd1;
      else if (jos6 && etaj6 != 3'd0) etaj6 <= etaj6 - 3'd1;
    end
  end

  // Activity monitor: stops, step pulses, door run lengths, step invariants.
  int   cyc = 0;
  int   stops[$];
  int   sus_times[$];
  int   door_lens[$];
  int   sus_cnt = 0, jos_cnt = 0, sus_after_stop = 0, door_run = 0;
  logic usa_prev = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        cyc++;
        if (usa_deschisa && !usa_prev) stops.push_back(int'(etaj));
        if (usa_deschisa) door_run++;
        else if (usa_prev) begin
          door_lens.push_back(door_run);
          door_run = 0;
        end
        if (sus) begin
          sus_cnt++;
          sus_times.push_back(cyc);
          if (stops.size() > 0) sus_after_stop++;
        end
        if (jos) jos_cnt++;
        checks++;
        if ((sus && jos) || ((sus || jos) && stare != 3'd2) ||
            (sus && etaj == 3'd7) || (jos && etaj == 3'd0)) begin
          failures++;
          $display("FAIL step_invariant: got sus=%0b jos=%0b stare=%0d floor=%0d required legal step",
                   sus, jos, stare, etaj);
        end
        usa_prev = usa_deschisa;
      end else begin
        usa_prev = 1'b0;
        door_run = 0;
      end
    end
  end

  task automatic tick_n(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic clear_mon();
    stops.delete();
    sus_times.delete();
    door_lens.delete();
    sus_cnt = 0;
    jos_cnt = 0;
    sus_after_stop = 0;
  endtask

  task automatic pulse_call(input logic [7:0] m);
    cerere = m;
    tick_n(1);
    cerere = 8'h00;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    tick_n(2);
    reset = 1'b1;
    tick_n(1);
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n;
    n = 0;
    while (!(stare == 3'd0 && cereri_active == 8'h00 && !usa_deschisa) && n < budget) begin
      tick_n(1);
      n++;
    end
    checks++;
    if (n >= budget) begin
      failures++;
      $display("FAIL %s_timeout: got stare=%0d pending=%h required idle within %0d cycles",
               name, stare, cereri_active, budget);
    end
  endtask

  task automatic wait_door(input int budget, input string name);
    int n;
    n = 0;
    while (!usa_deschisa && n < budget) begin
      tick_n(1);
      n++;
    end
    checks++;
    if (!usa_deschisa) begin
      failures++;
      $display("FAIL %s_door_timeout: got usa_deschisa=0 required 1 within %0d cycles", name, budget);
    end
  endtask

  // Reference: SCAN service order from a snapshot of calls taken while idle.
  int   exp_stops[$];
  logic exp_dir;
  int   exp_up, exp_down;

  task automatic predict(input int f, input logic d, input logic [7:0] m);
    int  pos;
    bit  any_behind;
    exp_stops.delete();
    any_behind = 0;
    if (m[f]) exp_stops.push_back(f);
    if (d) begin
      for (int k = f + 1; k < 8; k++) if (m[k]) exp_stops.push_back(k);
      for (int k = f - 1; k >= 0; k--) if (m[k]) begin exp_stops.push_back(k); any_behind = 1; end
    end else begin
      for (int k = f - 1; k >= 0; k--) if (m[k]) exp_stops.push_back(k);
      for (int k = f + 1; k < 8; k++) if (m[k]) begin exp_stops.push_back(k); any_behind = 1; end
    end
    exp_dir  = any_behind ? ~d : d;
    exp_up   = 0;
    exp_down = 0;
    pos = f;
    foreach (exp_stops[i]) begin
      if (exp_stops[i] > pos) exp_up += exp_stops[i] - pos;
      else exp_down += pos - exp_stops[i];
      pos = exp_stops[i];
    end
  endtask

  task automatic test_reset();
    tick_n(2);
    checks++; if (stare !== 3'd0) begin failures++; $display("FAIL reset_stare: got %0d required 0", stare); end
    checks++; if (sus !== 1'b0 || jos !== 1'b0) begin failures++; $display("FAIL reset_steps: got sus=%0b jos=%0b required 0 0", sus, jos); end
    checks++; if (usa_deschisa !== 1'b0) begin failures++; $display("FAIL reset_door: got %0b required 0", usa_deschisa); end
    checks++; if (cereri_active !== 8'h00) begin failures++; $display("FAIL reset_pending: got %h required 00", cereri_active); end
    checks++; if (directie !== 1'b1) begin failures++; $display("FAIL reset_dir: got %0b required 1", directie); end
    reset = 1'b1;
    tick_n(1);
    $display("txn reset: stare=%0d dir=%0b", stare, directie);
  endtask

  task automatic test_upward();
    int c0;
    clear_mon();
    c0 = cyc;
    pulse_call(8'h08);
    checks++; if (cereri_active !== 8'h08) begin failures++; $display("FAIL up_latch: got %h required 08", cereri_active); end
    wait_idle(200, "up");
    checks++; if (sus_cnt != 3 || jos_cnt != 0) begin failures++; $display("FAIL up_steps: got sus=%0d jos=%0d required 3 0", sus_cnt, jos_cnt); end
    checks++;
    if (sus_times.size() < 1 || sus_times[0] != c0 + 6) begin
      failures++; $display("FAIL up_latency: got first sus cycle %0d required %0d", sus_times.size() > 0 ? sus_times[0] : -1, c0 + 6);
    end
    for (int i = 1; i < sus_times.size(); i++) begin
      checks++;
      if (sus_times[i] - sus_times[i-1] != 6) begin failures++; $display("FAIL up_spacing: got %0d required 6", sus_times[i] - sus_times[i-1]); end
    end
    checks++; if (etaj !== 3'd3) begin failures++; $display("FAIL up_floor: got %0d required 3", etaj); end
    checks++; if (door_lens.size() != 1 || door_lens[0] != 3) begin failures++; $display("FAIL up_dwell: got %0d runs first=%0d required 1 run of 3", door_lens.size(), door_lens.size() > 0 ? door_lens[0] : -1); end
    $display("txn upward: steps=%0d floor=%0d", sus_cnt, etaj);
  endtask

  task automatic test_scan();
    apply_reset();
    pulse_call(8'h04);
    wait_idle(200, "scan_setup");
    clear_mon();
    pulse_call(8'h21);
    wait_idle(400, "scan");
    checks++; if (stops.size() != 2 || stops[0] != 5 || stops[1] != 0) begin failures++; $display("FAIL scan_order: got %0d stops first=%0d required 5 then 0", stops.size(), stops.size() > 0 ? stops[0] : -1); end
    checks++; if (sus_cnt != 3 || jos_cnt != 5) begin failures++; $display("FAIL scan_steps: got sus=%0d jos=%0d required 3 5", sus_cnt, jos_cnt); end
    checks++; if (sus_after_stop != 0) begin failures++; $display("FAIL scan_no_sus: got %0d required 0", sus_after_stop); end
    checks++; if (directie !== 1'b0) begin failures++; $display("FAIL scan_dir: got %0b required 0", directie); end
    $display("txn scan: stops=%0d up=%0d down=%0d dir=%0b", stops.size(), sus_cnt, jos_cnt, directie);
  endtask

  task automatic test_obstruction();
    clear_mon();
    pulse_call(8'h01);
    wait_door(10, "obstr");
    usa_blocata = 1'b1;
    tick_n(10);
    usa_blocata = 1'b0;
    wait_idle(100, "obstr");
    checks++; if (door_lens.size() != 1 || door_lens[0] != 13) begin failures++; $display("FAIL obstr_dwell: got %0d required 13", door_lens.size() > 0 ? door_lens[0] : -1); end
    $display("txn obstruction: dwell=%0d", door_lens.size() > 0 ? door_lens[0] : -1);
  endtask

  task automatic test_repress();
    clear_mon();
    pulse_call(8'h01);
    wait_door(10, "repress");
    tick_n(1);
    cerere = 8'h01;
    tick_n(1);
    cerere = 8'h00;
    checks++; if (cereri_active[0] !== 1'b0) begin failures++; $display("FAIL repress_pending: got %0b required 0", cereri_active[0]); end
    wait_idle(100, "repress");
    checks++; if (door_lens.size() != 1 || door_lens[0] != 5) begin failures++; $display("FAIL repress_dwell: got %0d required 5", door_lens.size() > 0 ? door_lens[0] : -1); end
    $display("txn repress: dwell=%0d", door_lens.size() > 0 ? door_lens[0] : -1);
  endtask

  task automatic test_reset_mid_move();
    int n;
    pulse_call(8'h02);
    n = 0;
    while (stare != 3'd2 && n < 50) begin tick_n(1); n++; end
    checks++; if (stare != 3'd2) begin failures++; $display("FAIL midrst_reach_step: got stare=%0d required 2", stare); end
    reset = 1'b0;
    #1;
    checks++; if (sus !== 1'b0 || jos !== 1'b0) begin failures++; $display("FAIL midrst_steps: got sus=%0b jos=%0b required 0 0", sus, jos); end
    checks++; if (stare !== 3'd0 || cereri_active !== 8'h00 || directie !== 1'b1 || usa_deschisa !== 1'b0) begin
      failures++; $display("FAIL midrst_outputs: got stare=%0d pend=%h dir=%0b door=%0b required 0 00 1 0", stare, cereri_active, directie, usa_deschisa);
    end
    tick_n(2);
    reset = 1'b1;
    clear_mon();
    tick_n(30);
    checks++; if (sus_cnt != 0 || jos_cnt != 0 || stare !== 3'd0) begin failures++; $display("FAIL midrst_quiet: got sus=%0d jos=%0d stare=%0d required 0 0 0", sus_cnt, jos_cnt, stare); end
    $display("txn reset_mid_move: floor=%0d stare=%0d", etaj, stare);
  endtask

  task automatic test_end_floors();
    clear_mon();
    pulse_call(8'h80);
    wait_idle(300, "top_travel");
    checks++; if (sus_cnt != 7 || etaj !== 3'd7) begin failures++; $display("FAIL top_travel: got sus=%0d floor=%0d required 7 7", sus_cnt, etaj); end
    clear_mon();
    pulse_call(8'h80);
    wait_idle(100, "top_door");
    checks++; if (sus_cnt != 0 || stops.size() != 1 || stops[0] != 7) begin failures++; $display("FAIL top_door: got sus=%0d stops=%0d required 0 sus, one stop at 7", sus_cnt, stops.size()); end
    // Six-floor instance: bit 7 is outside the served range.
    cerere6 = 8'h80;
    tick_n(1);
    cerere6 = 8'h00;
    tick_n(1);
    checks++; if (cereri6 !== 8'h00 || stare6 !== 3'd0) begin failures++; $display("FAIL oor_ignored: got pend=%h stare=%0d required 00 0", cereri6, stare6); end
    cerere6 = 8'h20;
    tick_n(1);
    cerere6 = 8'h00;
    checks++; if (cereri6 !== 8'h20) begin failures++; $display("FAIL oor_valid_latch: got %h required 20", cereri6); end
    $display("txn end_floors: top_sus=%0d pend6=%h", sus_cnt, cereri6);
  endtask

  task automatic test_random();
    logic [7:0] m;
    int         f;
    logic       d;
    apply_reset();
    d = 1'b1;
    for (int t = 0; t < 20; t++) begin
      m = 8'($urandom_range(1, 255));
      f = int'(etaj);
      predict(f, d, m);
      clear_mon();
      pulse_call(m);
      wait_idle(1000, "rand");
      checks++;
      if (stops.size() != exp_stops.size()) begin
        failures++; $display("FAIL rand_stop_count: txn %0d got %0d required %0d", t, stops.size(), exp_stops.size());
      end else begin
        foreach (exp_stops[i]) begin
          checks++;
          if (stops[i] != exp_stops[i]) begin failures++; $display("FAIL rand_stop: txn %0d idx %0d got %0d required %0d", t, i, stops[i], exp_stops[i]); end
        end
      end
      checks++; if (sus_cnt != exp_up || jos_cnt != exp_down) begin failures++; $display("FAIL rand_steps: txn %0d got up=%0d down=%0d required %0d %0d", t, sus_cnt, jos_cnt, exp_up, exp_down); end
      checks++; if (directie !== exp_dir) begin failures++; $display("FAIL rand_dir: txn %0d got %0b required %0b", t, directie, exp_dir); end
      $display("txn rand %0d: from=%0d calls=%h stops=%0d up=%0d down=%0d dir=%0b", t, f, m, stops.size(), sus_cnt, jos_cnt, directie);
      d = exp_dir;
    end
  endtask

  initial begin
    test_reset();
    test_upward();
    test_scan();
    test_obstruction();
    test_repress();
    test_reset_mid_move();
    test_end_floors();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/elevator_scheduler.md
# elevator_scheduler

Request-scheduling controller for the elevator car. It latches floor calls and chooses a travel direction with a SCAN policy: keep going while calls remain ahead, otherwise reverse. It issues single-cycle `sus`/`jos` step pulses to the floor counter and sequences the door open/dwell/close phase. It sits between the debounced call buttons and the floor counter, and reads the counter's `etaj_curent` back as its position.

## Interface
- `NUM_FLOORS`, default 8: number of served floors, range 2..8; floors are 0..NUM_FLOORS-1.
- `TRAVEL_TICKS`, default 50: `tick` pulses spent travelling between adjacent floors; must be ≥1.
- `DOOR_TICKS`, default 100: `tick` pulses the door stays open with no obstruction; must be ≥1.
- `clk`  in  1: single clock; all state changes on its rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `tick`  in  1: one-cycle timebase enable; all counters advance only when it is high.
- `cerere`  in  8: call pulses, one bit per floor; bits at index ≥NUM_FLOORS are ignored.
- `etaj_curent`  in  3: current floor from the floor counter.
- `usa_blocata`  in  1: door obstruction sensor, level-sensitive.
- `sus`  out  1: step-up pulse to the floor counter.
- `jos`  out  1: step-down pulse to the floor counter.
- `usa_deschisa`  out  1: door-open command.
- `cereri_active`  out  8: latched pending calls.
- `directie`  out  1: current/last travel direction, 1 = up, 0 = down.
- `stare`  out  3: state encoding, for debug and display.

## Operation
- States: IDLE=0, MOVE=1, STEP=2, SETTLE=3, DOOR_OPEN=4. Encodings 5–7 are illegal and go to IDLE on the next edge.
- Request latch:
  - `cerere[i]` high at an edge sets `cereri_active[i]`; the set is visible the next cycle.
  - Exception: in DOOR_OPEN, `cerere[etaj_curent]` is not latched; it restarts the door counter instead.
- "Ahead" means any pending bit strictly above `etaj_curent` when `directie`=1, or strictly below when `directie`=0. "Behind" is the opposite side.
- IDLE decision, in priority order:
  1. `cereri_active[etaj_curent]` set → DOOR_OPEN.
  2. A call ahead → MOVE.
  3. A call behind → toggle `directie`, then MOVE.
  4. Otherwise stay in IDLE.
- MOVE: the travel counter clears on entry and increments on each `tick`. On the edge where `tick`=1 and the count equals TRAVEL_TICKS-1 → STEP.
- STEP: lasts exactly one cycle.
  - `sus` = `directie`, `jos` = !`directie`.
  - Both outputs are decoded from the registered state (Moore), so neither glitches.
  - → SETTLE unconditionally.
- SETTLE: lasts one cycle so that `etaj_curent` reflects the step. It applies the IDLE decision list, except that case 4 goes to IDLE.
- DOOR_OPEN:
  - `usa_deschisa`=1.
  - `cereri_active[etaj_curent]` is cleared on the entry edge.
  - The door counter clears on entry and increments on each `tick`. `usa_blocata`=1 or `cerere[etaj_curent]`=1 clears it instead.
  - On the edge where `tick`=1, the count equals DOOR_TICKS-1 and no clearing condition is present → IDLE.
- Counters are $clog2(max+1) bits wide and saturate at their terminal value; they never wrap.
- Boundary rule: the scheduler never steps past the end floors.
  - It never issues `sus` at floor NUM_FLOORS-1 or `jos` at floor 0, because no call can be "ahead" past an end.
  - If `etaj_curent` ≥ NUM_FLOORS (fault), the block goes to IDLE and issues no steps.
- Simultaneous set and clear of the same bit: clear wins only for the current floor on DOOR_OPEN entry; a set of any other floor in the same cycle is kept.

## Timing
- Reset values: `stare`=IDLE, `sus`=0, `jos`=0, `usa_deschisa`=0, `cereri_active`=0, `directie`=1, both counters = 0.
- Reset asserted mid-operation: all outputs take their reset values immediately, with no completion of a pending step. The floor counter is reset in parallel by the top level.
- Call-to-motion latency: the call is latched at edge E0; IDLE sees it and enters MOVE at E1.
- Per floor, with `tick` tied high: TRAVEL_TICKS cycles in MOVE, 1 cycle in STEP, 1 cycle in SETTLE.
- The floor counter samples `sus`/`jos` at the edge that ends STEP; `etaj_curent` is valid during SETTLE.
- Door dwell with `tick` tied high and no obstruction: exactly DOOR_TICKS cycles of `usa_deschisa`=1.
- `sus` and `jos` are never high together and are never high outside STEP.

## Test plan
- Bench setup for all scenarios: TRAVEL_TICKS=4, DOOR_TICKS=3, `tick`=1.
- Upward call: from floor 0, pulse `cerere`=8'b0000_1000.
  - Response: exactly 3 `sus` pulses spaced 6 cycles apart; `etaj_curent`=3.
  - Then `usa_deschisa` high for 3 cycles, `cereri_active`=0, return to IDLE.
- SCAN order: at floor 2 moving up, with calls at floors 5 and 0.
  - Response: stops at 5 first; `directie` flips to 0; then 5 `jos` pulses to floor 0.
  - No `sus` is issued after the stop at floor 5.
- Obstruction: hold `usa_blocata`=1 for 10 cycles during DOOR_OPEN.
  - Response: `usa_deschisa` stays high for 10+3 cycles, then drops.
- Re-press the current floor during DOOR_OPEN.
  - Response: the door counter restarts; `cereri_active` for that floor stays 0.
- Reset mid-move: drive `reset`=0 while in STEP.
  - Response: `sus` drops combinationally; all outputs return to reset values; no further steps occur after reset is released without new calls.
- End floors and out-of-range calls:
  - With the car at floor 7, a call at floor 7 opens the door with no `sus` issued.
  - With NUM_FLOORS=6, a call on `cerere` bit 7 is ignored and `cereri_active` stays 0.
